bcd_to_bin_converter: RTL

//   Converts a packed BCD number into an unsigned binary value.

---
 rtl/bcd_to_bin_converter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_converter.sv
// bcd_to_bin_converter
// Turns a packed BCD number into its unsigned binary value using reverse
// double-dabble, one bit per clock. The BCD operand lives in the upper half
// of a 2W-bit shift register. Each iteration shifts the whole register right
// by one, so one BCD bit moves into the binary half. Any BCD digit that is
// then 8 or more is reduced by 3. After W iterations the lower half holds the
// binary result and the BCD half has drained to zero.
// Handshake: start is accepted only in IDLE. done pulses for one cycle when
// binary_out and error are valid. busy covers the whole transaction,
// including the done cycle.

module bcd_to_bin_converter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [4*DIGITS-1:0]   binary_out,
    output logic                  done,
    output logic                  busy,
    output logic                  error
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2*W-1:0]    sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      binary_out_q, binary_out_d;
    logic              error_q, error_d;

    logic [2*W-1:0]    shifted;
    logic [2*W-1:0]    corrected;
    logic              last_iter;

    // True when any nibble of a packed BCD word is outside 0..9.
    function automatic logic has_invalid_digit(input logic [W-1:0] value);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // A shifted-in 1 in a digit's MSB represents 5, not 8, so any digit of
    // 8 or more needs 3 removed to stay a correct half of the prior value.
    function automatic logic [W-1:0] correct_digits(input logic [W-1:0] value);
        logic [W-1:0] result;
        result = value;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] >= 4'd8) begin
                result[4*i +: 4] = value[4*i +: 4] - 4'd3;
            end
        end
        return result;
    endfunction

    // One iteration of the datapath: shift right, then fix the BCD half.
    always_comb begin
        shifted   = {1'b0, sr_q[2*W-1:1]};
        corrected = {correct_digits(shifted[2*W-1:W]), shifted[W-1:0]};
        last_iter = (cnt_q == CW'(W - 1));
    end

    // Next-state and datapath control. The result registers only move when
    // the FSM enters DONE, so the outputs hold steady while shifting.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        binary_out_d = binary_out_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d  = {bcd_in, {W{1'b0}}};
                    cnt_d = '0;
                    if (has_invalid_digit(bcd_in)) begin
                        binary_out_d = '0;
                        error_d      = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                sr_d  = corrected;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    binary_out_d = corrected[W-1:0];
                    error_d      = 1'b0;
                    state_d      = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            binary_out_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            binary_out_q <= binary_out_d;
            error_q      <= error_d;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        done       = (state_q == DONE);
        busy       = (state_q != IDLE);
        binary_out = binary_out_q;
        error      = error_q;
    end

    // A valid BCD operand must be fully consumed by the last iteration.
    bcd_half_drained: assert property (
        @(posedge clk) disable iff (reset)
        (state_q == SHIFT && last_iter) |-> (corrected[2*W-1:W] == '0)
    );

endmodule
